vga_scan: RTL and testbench

Display-side reader for the PPU framebuffer. Generates 640x480@60 VGA timing from `pix_clk`, walks the framebuffer read port (`pix_ptr_x`/`pix_ptr_y`) with 2x pixel doubling so the 256x240 PPU image fills a centred 512x480 window, and drives VGA pins from the returned 9-bit `rgb`. It also emits a once-per-frame tick so the PPU controller can align its writes to display blanking.

---
 rtl/vga_scan.sv | 134 +++++++++++++
 tb/tb_vga_scan.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan.sv
// 640x480@60 VGA scan-out of a 256x240 framebuffer, 2x doubled into a centred 512x480 window.
// Pins lag the counters by 2 pix_clk; `VGA_SCAN_BORDER_EN paints the pillarbox with BORDER_RGB.
module vga_scan #(
  parameter int          H_VIS      = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_VIS      = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter int          X_OFS      = 64,
  parameter logic [8:0]  BORDER_RGB = 9'h000
) (
  input  logic       pix_clk,
  input  logic       rst_n,
  output logic [7:0] pix_ptr_x,
  output logic [7:0] pix_ptr_y,
  input  logic [8:0] rgb,
  output logic [2:0] vga_r,
  output logic [2:0] vga_g,
  output logic [2:0] vga_b,
  output logic       vga_hs_n,
  output logic       vga_vs_n,
  output logic       vga_de,
  output logic       frame_tick
);

  localparam logic [9:0] H_LAST  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_C = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C = 10'(V_VIS);
  localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] WIN_BEG = 10'(X_OFS);
  localparam logic [9:0] WIN_END = 10'(X_OFS + 512);

`ifdef VGA_SCAN_BORDER_EN
  localparam logic [8:0] BORDER_COL = BORDER_RGB;
`else
  localparam logic [8:0] BORDER_COL = BORDER_RGB & 9'h000;
`endif

  logic [9:0] r_hcnt;
  logic [9:0] r_vcnt;
  logic       w_vis;
  logic       w_win;
  logic       w_hs;
  logic       w_vs;
  logic       w_tick;
  logic [9:0] w_xofs;
  logic [8:0] w_col;

  logic       r_s1_vis;
  logic       r_s1_win;
  logic       r_s1_hs;
  logic       r_s1_vs;
  logic       r_s1_tick;

  logic [8:0] r_col;
  logic       r_hs_n;
  logic       r_vs_n;
  logic       r_de;
  logic       r_tick;

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hcnt <= 10'd0;
      r_vcnt <= 10'd0;
    end else if (r_hcnt == H_LAST) begin
      r_hcnt <= 10'd0;
      r_vcnt <= (r_vcnt == V_LAST) ? 10'd0 : r_vcnt + 10'd1;
    end else begin
      r_hcnt <= r_hcnt + 10'd1;
    end
  end

  assign w_vis  = (r_hcnt < H_VIS_C) && (r_vcnt < V_VIS_C);
  assign w_win  = w_vis && (r_hcnt >= WIN_BEG) && (r_hcnt < WIN_END);
  assign w_hs   = (r_hcnt >= HS_BEG) && (r_hcnt < HS_END);
  assign w_vs   = (r_vcnt >= VS_BEG) && (r_vcnt < VS_END);
  assign w_tick = (r_hcnt == 10'd0) && (r_vcnt == V_VIS_C);
  assign w_xofs = r_hcnt - WIN_BEG;

  // Halving both coordinates gives the 2x2 pixel doubling.
  assign pix_ptr_x = w_win ? 8'(w_xofs >> 1) : 8'd0;
  assign pix_ptr_y = w_win ? 8'(r_vcnt >> 1) : 8'd0;

  // Stage 1 holds the region flags while the framebuffer returns rgb.
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vis  <= 1'b0;
      r_s1_win  <= 1'b0;
      r_s1_hs   <= 1'b0;
      r_s1_vs   <= 1'b0;
      r_s1_tick <= 1'b0;
    end else begin
      r_s1_vis  <= w_vis;
      r_s1_win  <= w_win;
      r_s1_hs   <= w_hs;
      r_s1_vs   <= w_vs;
      r_s1_tick <= w_tick;
    end
  end

  assign w_col = r_s1_win ? rgb : (r_s1_vis ? BORDER_COL : 9'd0);

  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col  <= 9'd0;
      r_hs_n <= 1'b1;
      r_vs_n <= 1'b1;
      r_de   <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_col  <= w_col;
      r_hs_n <= ~r_s1_hs;
      r_vs_n <= ~r_s1_vs;
      r_de   <= r_s1_vis;
      r_tick <= r_s1_tick;
    end
  end

  assign vga_r      = r_col[8:6];
  assign vga_g      = r_col[5:3];
  assign vga_b      = r_col[2:0];
  assign vga_hs_n   = r_hs_n;
  assign vga_vs_n   = r_vs_n;
  assign vga_de     = r_de;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_vga_scan.sv
// Scoreboard bench for vga_scan with a shortened vertical frame (24 visible lines) to keep runs short.
module tb_vga_scan;

  localparam int H_TOT  = 800;
  localparam int V_VIS  = 24;
  localparam int V_FP   = 1;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 1;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME  = H_TOT * V_TOT;

`ifdef VGA_SCAN_BORDER_EN
  localparam logic [8:0] BORDER_EXP = 9'h1C0;
  localparam int BRD_R = 7;
`else
  localparam logic [8:0] BORDER_EXP = 9'h000;
  localparam int BRD_R = 0;
`endif

  typedef struct {
    int          h;
    int          v;
    int          px;
    int          py;
    logic [12:0] pins;
  } exp_t;

  logic       pix_clk = 1'b0;
  logic       rst_n;
  logic [7:0] pix_ptr_x, pix_ptr_y;
  logic [8:0] rgb;
  logic [2:0] vga_r, vga_g, vga_b;
  logic       vga_hs_n, vga_vs_n, vga_de, frame_tick;

  int   n_checks = 0;
  int   n_err    = 0;
  bit   running  = 1'b0;
  int   cyc;
  exp_t q[$];
  int   map_x[6] = '{0, 0, 1, 1, 2, 2};

  // measurement state
  int m_k, last_hs, hs_low, last_vs, vs_low, de_run, de_lines, last_tick, ticks;
  bit prev_hs, prev_vs, prev_de;

  vga_scan #(
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .BORDER_RGB(9'h1C0)
  ) dut (
    .pix_clk(pix_clk), .rst_n(rst_n), .pix_ptr_x(pix_ptr_x), .pix_ptr_y(pix_ptr_y),
    .rgb(rgb), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs_n(vga_hs_n),
    .vga_vs_n(vga_vs_n), .vga_de(vga_de), .frame_tick(frame_tick)
  );

  initial forever #5 pix_clk = ~pix_clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input int k);
    exp_t e;
    int t;
    bit vis, win, hs, vs, tk;
    logic [7:0] x8, y8;
    logic [8:0] col;
    t    = k % FRAME;
    e.h  = t % H_TOT;
    e.v  = t / H_TOT;
    vis  = (e.h < 640) && (e.v < V_VIS);
    win  = vis && (e.h >= 64) && (e.h < 64 + 512);
    e.px = win ? (e.h - 64) / 2 : 0;
    e.py = win ? e.v / 2 : 0;
    x8   = 8'(e.px);
    y8   = 8'(e.py);
    col  = win ? {x8[2:0], y8[2:0], 3'b100} : (vis ? BORDER_EXP : 9'd0);
    hs   = (e.h >= 656) && (e.h < 752);
    vs   = (e.v >= V_VIS + V_FP) && (e.v < V_VIS + V_FP + V_SYNC);
    tk   = (e.h == 0) && (e.v == V_VIS);
    e.pins = {col, ~hs, ~vs, vis, tk};
    return e;
  endfunction

  function automatic exp_t reset_entry();
    exp_t e;
    e.h = -1; e.v = -1; e.px = 0; e.py = 0;
    e.pins = {9'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    return e;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_pins"}, int'({vga_r, vga_g, vga_b, vga_hs_n, vga_vs_n, vga_de, frame_tick}),
        int'(reset_entry().pins));
    chk({tag, "_ptr_x"}, int'(pix_ptr_x), 0);
    chk({tag, "_ptr_y"}, int'(pix_ptr_y), 0);
  endtask

  task automatic start_run();
    q.delete();
    q.push_back(reset_entry());
    q.push_back(model(0));
    cyc = 0;
    m_k = 0; last_hs = -1; hs_low = 0; last_vs = -1; vs_low = 0;
    de_run = 0; de_lines = 0; last_tick = -1; ticks = 0;
    prev_hs = 1'b1; prev_vs = 1'b1; prev_de = 1'b0;
    running = 1'b1;
  endtask

  // Framebuffer model: one-cycle read latency.
  initial begin
    logic [7:0] px, py;
    rgb = 9'd0;
    forever begin
      @(negedge pix_clk);
      px = pix_ptr_x;
      py = pix_ptr_y;
      @(posedge pix_clk);
      #1 rgb = {px[2:0], py[2:0], 3'b100};
    end
  end

  // Stimulus side: each new counter state pushes its expected pin response.
  always @(posedge pix_clk) begin
    exp_t e;
    #1;
    if (running) begin
      cyc++;
      e = model(cyc);
      q.push_back(e);
      chk("ptr_x", int'(pix_ptr_x), e.px);
      chk("ptr_y", int'(pix_ptr_y), e.py);
      if (e.v == 23 && e.h >= 64 && e.h <= 69) begin
        chk("map_x", int'(pix_ptr_x), map_x[e.h - 64]);
        chk("map_y", int'(pix_ptr_y), 11);
      end
      if (e.v == 23 && (e.h == 63 || e.h == 576)) begin
        chk("edge_x", int'(pix_ptr_x), 0);
        chk("edge_y", int'(pix_ptr_y), 0);
      end
    end
  end

  // Monitor: pops one expectation per output cycle.
  always @(negedge pix_clk) begin
    exp_t m;
    logic [12:0] act;
    if (running) begin
      act = {vga_r, vga_g, vga_b, vga_hs_n, vga_vs_n, vga_de, frame_tick};
      if (q.size() == 0) begin
        chk("scoreboard_empty", 1, 0);
      end else begin
        m = q.pop_front();
        chk($sformatf("pins h=%0d v=%0d", m.h, m.v), int'(act), int'(m.pins));
        if (m.h == 68 && m.v == 0) begin
          chk("entry_r", int'(vga_r), 2);
          chk("entry_g", int'(vga_g), 0);
          chk("entry_b", int'(vga_b), 4);
        end
        if (m.h == 10 && m.v == 3) begin
          chk("border_r", int'(vga_r), BRD_R);
          chk("border_g", int'(vga_g), 0);
          chk("border_b", int'(vga_b), 0);
        end
      end
    end
  end

  // Independent period / width measurements on the pins.
  always @(negedge pix_clk) begin
    if (running) begin
      m_k++;
      if (prev_hs && !vga_hs_n) begin
        if (last_hs < 0) chk("first_hs_fall", m_k, 658);
        else             chk("hs_period", m_k - last_hs, 800);
        last_hs = m_k;
        hs_low  = 0;
      end
      if (!vga_hs_n) hs_low++;
      if (!prev_hs && vga_hs_n) chk("hs_low", hs_low, 96);
      if (prev_vs && !vga_vs_n) begin
        if (last_vs >= 0) chk("vs_period", m_k - last_vs, FRAME);
        last_vs = m_k;
        vs_low  = 0;
      end
      if (!vga_vs_n) vs_low++;
      if (!prev_vs && vga_vs_n) chk("vs_low", vs_low, 1600);
      if (vga_de) de_run++;
      if (prev_de && !vga_de) begin
        chk("de_width", de_run, 640);
        de_lines++;
        de_run = 0;
      end
      if (frame_tick) begin
        chk("tick_vs_n", int'(vga_vs_n), 1);
        chk("tick_de", int'(vga_de), 0);
        chk("tick_de_lines", de_lines, V_VIS);
        if (last_tick < 0) chk("first_tick", m_k, V_VIS * H_TOT + 2);
        else               chk("tick_period", m_k - last_tick, FRAME);
        last_tick = m_k;
        de_lines  = 0;
        ticks++;
      end
      prev_hs = vga_hs_n;
      prev_vs = vga_vs_n;
      prev_de = vga_de;
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (5) @(posedge pix_clk);
    #2 check_reset("init");
    @(negedge pix_clk);
    #2 rst_n = 1'b1;
    start_run();
    // Two full frames, then stop mid-line at v=5, h=100 of the third.
    repeat (2 * FRAME + 5 * H_TOT + 100) @(posedge pix_clk);
    #2 rst_n = 1'b0;
    running = 1'b0;
    #1 check_reset("midframe");
    chk("ticks_phase1", ticks, 2);
    repeat (3) @(posedge pix_clk);
    #2 check_reset("held");
    @(negedge pix_clk);
    #2 rst_n = 1'b1;
    start_run();
    repeat (V_VIS * H_TOT + 2 + 200) @(posedge pix_clk);
    #3 chk("ticks_phase2", ticks, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
